// File: rtl/dds_burst_sched_if.sv
// Command bus between host/control logic and the DDS burst scheduler.
// Carries valid/ready handshake, command fields and the abort request.
interface dds_burst_sched_if #(
    parameter int LEN_W = 16,
    parameter int REP_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_sel;
    logic [LEN_W-1:0] cmd_len;
    logic [LEN_W-1:0] cmd_gap;
    logic [REP_W-1:0] cmd_rep;
    logic             abort;

    modport master (
        output cmd_valid,
        output cmd_sel,
        output cmd_len,
        output cmd_gap,
        output cmd_rep,
        output abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_sel,
        input  cmd_len,
        input  cmd_gap,
        input  cmd_rep,
        input  abort,
        output cmd_ready
    );
endinterface

// File: rtl/dds_burst_sched.sv
// Burst scheduler for DDS generators: sequences one-hot dds_en lines and
// muxes the selected generator sample onto a shared registered DAC output.
// Ports: clk, rst (sync, active high), cmd (command bus, slave side),
//   wave_en (one-hot generator enables), wave_q (packed generator samples),
//   dout/dout_valid (scheduled sample), busy, done pulse, cmd_err pulse.
module dds_burst_sched #(
    parameter int DW      = 8,
    parameter int NWAV    = 4,
    parameter int LEN_W   = 16,
    parameter int REP_W   = 8,
    parameter int ROM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    dds_burst_sched_if.slave     cmd,
    output logic [NWAV-1:0]      wave_en,
    input  logic [NWAV*DW-1:0]   wave_q,
    output logic [DW-1:0]        dout,
    output logic                 dout_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 cmd_err
);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        BURST,
        GAP,
        FIN
    } state_t;

    localparam logic [LEN_W-1:0] PRIME_LAST = LEN_W'(ROM_LAT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       sel_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] gap_q;
    logic [REP_W-1:0] rep_q;
    logic [LEN_W-1:0] cnt_q;

    logic accept;
    logic sel_bad;
    logic burst_end;
    logic more_reps;
    logic ready;
    logic out_load;

    assign ready         = (state_q == IDLE);
    assign cmd.cmd_ready = ready;
    assign accept        = cmd.cmd_valid & ready;
    assign sel_bad       = ({30'd0, cmd.cmd_sel} >= 32'(NWAV));
    assign burst_end     = (state_q == BURST) && (cnt_q == len_q - 1'b1);
    assign more_reps     = (rep_q > REP_W'(1));
    // Abort must also suppress the beat that BURST would otherwise register.
    assign out_load      = (state_q == BURST) && !cmd.abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wave_en = '0;
        busy    = (state_q != IDLE);
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && !sel_bad) begin
                    state_d = (cmd.cmd_len == '0) ? FIN : PRIME;
                end
            end
            PRIME: begin
                if (cnt_q == PRIME_LAST) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                if (burst_end) begin
                    if (more_reps) begin
                        state_d = (gap_q == '0) ? PRIME : GAP;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            GAP: begin
                if (cnt_q == gap_q - 1'b1) begin
                    state_d = PRIME;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (cmd.abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
        if ((state_q == PRIME) || (state_q == BURST)) begin
            for (int i = 0; i < NWAV; i++) begin
                wave_en[i] = (int'(sel_q) == i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q      <= '0;
            len_q      <= '0;
            gap_q      <= '0;
            rep_q      <= '0;
            cnt_q      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            cmd_err <= accept && sel_bad;
            if (accept) begin
                sel_q <= cmd.cmd_sel;
                len_q <= cmd.cmd_len;
                gap_q <= cmd.cmd_gap;
                rep_q <= (cmd.cmd_rep == '0) ? REP_W'(1) : cmd.cmd_rep;
            end else if (burst_end && more_reps) begin
                rep_q <= rep_q - 1'b1;
            end
            // Phase counter restarts on every state change.
            cnt_q <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
            dout_valid <= out_load;
            dout <= out_load ? wave_q[int'(sel_q)*DW +: DW] : '0;
        end
    end

endmodule
